mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single synchronous RAM between two masters: port 0 = CPU
//   (state controller fetch/LDR/STR path), port 1 = memory loader/debug port.
// - Sits between both masters and the RAM.
// - Each port issues mem_cmd-encoded requests (MNONE/MREAD/MWRITE).
// - A 3-state FSM serialises the requests, round-robin on contention; read data is returned to the owning port.
// PARAMETERS
// - ADDR_W  9   RAM address width
// - DATA_W  16  RAM data width
// PORTS
// - clk          in   1       single clock, rising edge
// - rst          in   1       synchronous, active-high reset
// - m0_cmd       in   2       port 0 command: 00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal
// - m0_addr      in   ADDR_W  port 0 address
// - m0_wdata     in   DATA_W  port 0 write data
// - m0_gnt       out  1       port 0 request accepted (1-cycle pulse)
// - m0_rvalid    out  1       port 0 read data valid (1-cycle pulse)
// - m0_rdata     out  DATA_W  port 0 read data
// - m1_*         same set as m0_*, for port 1
// - ram_addr     out  ADDR_W  RAM address
// - ram_wdata    out  DATA_W  RAM write data
// - ram_read     out  1       RAM read strobe
// - ram_write    out  1       RAM write strobe
// - ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after ram_read
// - busy         out  1       FSM not in ARB_IDLE
// - err_illegal  out  1       sticky: a cmd 2'b11 was seen
// BEHAVIOUR
// - Reset:
//   - state=ARB_IDLE, last_owner=1 (port 0 wins the first tie).
//   - All outputs 0, err_illegal=0.
//   - Latched cmd/addr/wdata cleared.
// - ARB_IDLE:
//   - A port requests when its cmd is MREAD or MWRITE.
//   - Winner: the sole requester; on contention, the port != last_owner.
//   - Latch owner, cmd, addr, wdata; last_owner<=owner; next ARB_ACCESS.
//   - No request: stay in ARB_IDLE.
// - ARB_ACCESS (Moore outputs from latched regs):
//   - ram_addr/ram_wdata are driven from the latched values.
//   - ram_read = (cmd==MREAD); ram_write = (cmd==MWRITE).
//   - mN_gnt=1 for the owner only.
//   - Next: ARB_RESP for a read, ARB_IDLE for a write.
// - ARB_RESP:
//   - Owner's mN_rdata <= ram_rdata with mN_rvalid=1 this cycle.
//   - mN_rdata holds its value until the next read for that port; next ARB_IDLE.
// - Latency from request seen in IDLE:
//   - Write: gnt at +1 cycle, committed at the edge ending ACCESS; 2 cycles/op.
//   - Read: gnt at +1, rvalid at +2; 3 cycles/op.
// - Master rule:
//   - Hold cmd/addr/wdata stable until mN_gnt.
//   - After mN_gnt, the cmd seen in the next IDLE is a new request.
//   - A master must not issue a new read before rvalid of its previous read.
// - Illegal cmd 2'b11: treated as MNONE (never granted); sets err_illegal, which stays set until rst.
// - The non-owner's gnt/rvalid are 0; its request waits, and latency is bounded at 3 cycles under round-robin.
// - Reset mid-operation:
//   - ram_read/ram_write are gated with !rst, so no RAM access occurs in a cycle with rst=1.
//   - The pending transaction is dropped: no rvalid; next state ARB_IDLE.
// - Width: addr/data pass through unmodified; no arithmetic.
// CONFIGURATION
// - Macro: MEM_ARB_FIXED_PRIO_EN
// - Defined: on contention port 0 always wins; last_owner is unused.
// - Undefined (default): round-robin as above.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - MNONE/MREAD/MWRITE constants (2-bit).
//   - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}.
// - Sub-module arb_pick2 (combinational): inputs req[1:0] and last_owner;
//   outputs winner and valid. It holds the round-robin/fixed-priority choice under the macro.
// TESTING
// 1. Hold rst 2 cycles with random inputs -> all outputs 0, busy=0, err_illegal=0.
// 2. m0 MREAD addr 9'h005, RAM[5]=16'hABCD ->
//    - m0_gnt at +1 with ram_read=1 and ram_addr=5.
//    - m0_rvalid=1 and m0_rdata=16'hABCD at +2.
// 3. m1 MWRITE addr 9'h010 data 16'h1234 -> ram_write=1 with addr/data at +1 and m1_gnt=1.
//    A following m0 MREAD 9'h010 returns 16'h1234.
// 4. Both ports request back-to-back reads -> grants alternate 0,1,0,1.
//    With MEM_ARB_FIXED_PRIO_EN: port 0 is always granted.
// 5. m1_cmd=2'b11 -> no ram strobe and no m1_gnt; err_illegal=1 persists until rst.
// 6. rst asserted in the ACCESS cycle of an m0 read -> ram_read=0 that cycle, no m0_rvalid, IDLE next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Contents:
//   MNONE / MREAD / MWRITE / MILLEGAL  2-bit mem_cmd encodings
//   arb_state_t                        arbiter FSM states
//   is_req()                           true for a command that needs the RAM
package mem_arb_pkg;

  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;
  localparam logic [1:0] MILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // The illegal encoding is deliberately excluded so that it is never granted.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Two-requester winner selection for mem_port_arbiter.
// Ports:
//   req[1:0]    in   request per port (bit N = port N)
//   last_owner  in   port granted most recently
//   winner      out  selected port (meaningful when valid=1)
//   valid       out  at least one port is requesting
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 win every tie;
// otherwise a tie goes to the port that did not own the RAM last.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  // Winner selection: sole requester wins, a tie uses the configured policy.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11:   winner = 1'b0;
`else
      2'b11:   winner = ~last_owner;
`endif
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM between port 0 (CPU) and port 1 (loader/debug).
// Requests are serialised by an IDLE -> ACCESS (-> RESP) FSM; read data is
// steered back to the port that issued the read.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mN_cmd/mN_addr/mN_wdata          port N request (MNONE/MREAD/MWRITE)
//   mN_gnt                           port N request accepted (1-cycle pulse)
//   mN_rvalid/mN_rdata               port N read data (rdata holds afterwards)
//   ram_addr/ram_wdata/ram_read/ram_write/ram_rdata   RAM interface
//   busy                             FSM not idle
//   err_illegal                      sticky: a 2'b11 command was observed
// Build option: MEM_ARB_FIXED_PRIO_EN (see arb_pick2) selects fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              err_illegal
);

  arb_state_t        state_r, state_s;
  logic              owner_r, last_owner_r;
  logic [1:0]        cmd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata0_r, rdata1_r;
  logic              err_r;
  logic [1:0]        req_s;
  logic              winner_s, pick_valid_s;
  logic              in_access_s, in_resp_s;

  assign req_s = {is_req(m1_cmd), is_req(m0_cmd)};

  arb_pick2 u_pick (
    .req        (req_s),
    .last_owner (last_owner_r),
    .winner     (winner_s),
    .valid      (pick_valid_s)
  );

  // State register, request latch, per-port read-data hold and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      cmd_r        <= MNONE;
      addr_r       <= '0;
      wdata_r      <= '0;
      rdata0_r     <= '0;
      rdata1_r     <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ARB_IDLE) && pick_valid_s) begin
        owner_r      <= winner_s;
        last_owner_r <= winner_s;
        cmd_r        <= winner_s ? m1_cmd : m0_cmd;
        addr_r       <= winner_s ? m1_addr : m0_addr;
        wdata_r      <= winner_s ? m1_wdata : m0_wdata;
      end
      if (state_r == ARB_RESP) begin
        if (owner_r) rdata1_r <= ram_rdata;
        else         rdata0_r <= ram_rdata;
      end
      if ((m0_cmd == MILLEGAL) || (m1_cmd == MILLEGAL)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB_IDLE:   state_s = pick_valid_s ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS: state_s = (cmd_r == MREAD) ? ARB_RESP : ARB_IDLE;
      ARB_RESP:   state_s = ARB_IDLE;
      default:    state_s = ARB_IDLE;
    endcase
  end

  // Moore outputs from the latched request. Grants, strobes and rvalid are
  // suppressed while rst is high so an interrupted transaction leaves no
  // trace on the RAM or on either master.
  always_comb begin
    in_access_s = (state_r == ARB_ACCESS) && !rst;
    in_resp_s   = (state_r == ARB_RESP) && !rst;
    ram_addr    = addr_r;
    ram_wdata   = wdata_r;
    ram_read    = in_access_s && (cmd_r == MREAD);
    ram_write   = in_access_s && (cmd_r == MWRITE);
    m0_gnt      = in_access_s && !owner_r;
    m1_gnt      = in_access_s && owner_r;
    m0_rvalid   = in_resp_s && !owner_r;
    m1_rvalid   = in_resp_s && owner_r;
    // RAM data is forwarded in the RESP cycle itself, then held in rdataN_r.
    m0_rdata    = m0_rvalid ? ram_rdata : rdata0_r;
    m1_rdata    = m1_rvalid ? ram_rdata : rdata1_r;
    busy        = (state_r != ARB_IDLE);
    err_illegal = err_r;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural RAM, directed
// master transactions, and a scoreboard monitor that matches every grant
// and read-data pulse against queued expectations.
module tb_mem_port_arbiter;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m0_cmd = 2'b00, m1_cmd = 2'b00;
  logic [8:0]  m0_addr = 9'd0, m1_addr = 9'd0;
  logic [15:0] m0_wdata = 16'd0, m1_wdata = 16'd0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [8:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_read, ram_write;
  logic [15:0] ram_rdata = 16'd0;
  logic        busy, err_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_rvalid;
    bit          port;
    bit          is_write;
    logic [8:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] mem [0:511];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_rdata(ram_rdata),
    .busy(busy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: read data one cycle after ram_read.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input bit port, input bit is_write, input logic [8:0] addr,
                          input logic [15:0] data);
    exp_t e;
    e.is_rvalid = 1'b0; e.port = port; e.is_write = is_write; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_rv(input bit port, input logic [15:0] data);
    exp_t e;
    e.is_rvalid = 1'b1; e.port = port; e.is_write = 1'b0; e.addr = 9'd0; e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every grant or rvalid pulse consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m0_gnt || m1_gnt) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_gnt: got m0_gnt=%b m1_gnt=%b expected none at %0t", m0_gnt, m1_gnt, $time);
      end else begin
        e = exp_q.pop_front();
        check("gnt_kind", 32'(e.is_rvalid), 32'd0);
        check("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
        check("gnt_port", 32'(m1_gnt), 32'(e.port));
        check("ram_read", 32'(ram_read), 32'(!e.is_write));
        check("ram_write", 32'(ram_write), 32'(e.is_write));
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        if (e.is_write) check("ram_wdata", 32'(ram_wdata), 32'(e.data));
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rvalid: got m0_rvalid=%b m1_rvalid=%b expected none at %0t", m0_rvalid, m1_rvalid, $time);
      end else begin
        e = exp_q.pop_front();
        check("rv_kind", 32'(e.is_rvalid), 32'd1);
        check("rv_port", 32'(m1_rvalid), 32'(e.port));
        check("rv_data", 32'(m1_rvalid ? m1_rdata : m0_rdata), 32'(e.data));
      end
    end
  end

  // One master transaction; call at a negedge. Holds the request until gnt,
  // then for reads waits for rvalid. Expired waits count as failures.
  task automatic master_op(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wdata, input bit push, input logic [15:0] exp_rd);
    bit got;
    if (push) begin
      push_gnt(port, cmd == C_WRITE, addr, wdata);
      if (cmd == C_READ) push_rv(port, exp_rd);
    end
    if (port) begin m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata; end
    else      begin m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? m1_gnt : m0_gnt;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
    if (port) m1_cmd = C_NONE; else m0_cmd = C_NONE;
    if (cmd == C_READ) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = port ? m1_rvalid : m0_rvalid;
      end
      if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    for (int i = 0; i < 512; i++) mem[i] = 16'd0;
    mem[9'h005] = 16'hABCD;
    mem[9'h020] = 16'h1111;
    mem[9'h021] = 16'h2222;
    mem[9'h030] = 16'h3333;
    mem[9'h031] = 16'h4444;

    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m0_cmd = 2'($urandom_range(0, 3)); m1_cmd = 2'($urandom_range(0, 3));
      m0_addr = 9'($urandom); m1_addr = 9'($urandom);
      m0_wdata = 16'($urandom); m1_wdata = 16'($urandom);
      @(negedge clk);
    end
    check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    check("rst_ram_ctl", 32'({ram_read, ram_write}), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    m0_cmd = C_NONE; m1_cmd = C_NONE;
    rst = 1'b0;
    @(negedge clk);

    // 2: m0 read of RAM[5]
    master_op(1'b0, C_READ, 9'h005, 16'h0000, 1'b1, 16'hABCD);
    // 3: m1 write then m0 read-back
    master_op(1'b1, C_WRITE, 9'h010, 16'h1234, 1'b1, 16'h0000);
    master_op(1'b0, C_READ, 9'h010, 16'h0000, 1'b1, 16'h1234);
    master_op(1'b1, C_READ, 9'h005, 16'h0000, 1'b1, 16'hABCD);
    @(negedge clk);
    check("m0_rdata_hold", 32'(m0_rdata), 32'h1234);
    check("m1_rdata_hold", 32'(m1_rdata), 32'hABCD);
    check("idle_busy", 32'(busy), 32'd0);

    // 5: illegal command on m1
    m1_cmd = C_ILL; m1_addr = 9'h055;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ill_no_strobe", 32'({ram_read, ram_write}), 32'd0);
      check("ill_no_gnt", 32'(m1_gnt), 32'd0);
      check("ill_err", 32'(err_illegal), 32'd1);
    end
    m1_cmd = C_NONE;
    master_op(1'b1, C_READ, 9'h005, 16'h0000, 1'b1, 16'hABCD);
    @(negedge clk);
    check("ill_err_sticky", 32'(err_illegal), 32'd1);

    // 6: reset during the ACCESS cycle of an m0 read
    m0_cmd = C_READ; m0_addr = 9'h005;
    @(posedge clk);
    #1;
    check("rst6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst6_ram_read", 32'(ram_read), 32'd0);
    m0_cmd = C_NONE;
    @(posedge clk);
    #1;
    check("rst6_busy_after", 32'(busy), 32'd0);
    check("rst6_no_rvalid", 32'(m0_rvalid), 32'd0);
    check("rst6_err_clr", 32'(err_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst6_quiet", 32'({m0_rvalid, m0_gnt, busy}), 32'd0);
    end

    // 4: both ports issue two reads each, starting from a fresh tie state
`ifdef MEM_ARB_FIXED_PRIO_EN
    push_gnt(1'b0, 1'b0, 9'h020, 16'h0); push_rv(1'b0, 16'h1111);
    push_gnt(1'b0, 1'b0, 9'h021, 16'h0); push_rv(1'b0, 16'h2222);
    push_gnt(1'b1, 1'b0, 9'h030, 16'h0); push_rv(1'b1, 16'h3333);
    push_gnt(1'b1, 1'b0, 9'h031, 16'h0); push_rv(1'b1, 16'h4444);
`else
    push_gnt(1'b0, 1'b0, 9'h020, 16'h0); push_rv(1'b0, 16'h1111);
    push_gnt(1'b1, 1'b0, 9'h030, 16'h0); push_rv(1'b1, 16'h3333);
    push_gnt(1'b0, 1'b0, 9'h021, 16'h0); push_rv(1'b0, 16'h2222);
    push_gnt(1'b1, 1'b0, 9'h031, 16'h0); push_rv(1'b1, 16'h4444);
`endif
    fork
      begin
        master_op(1'b0, C_READ, 9'h020, 16'h0, 1'b0, 16'h0);
        master_op(1'b0, C_READ, 9'h021, 16'h0, 1'b0, 16'h0);
      end
      begin
        master_op(1'b1, C_READ, 9'h030, 16'h0, 1'b0, 16'h0);
        master_op(1'b1, C_READ, 9'h031, 16'h0, 1'b0, 16'h0);
      end
    join
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
